alu_result_display: RTL and testbench
=====================================

Name: alu_result_display

Overview:
- Downstream stage of the 4-bit signed ALU on the FPGA lab board.
- Takes the ALU's 8-bit signed result, converts it to sign plus three decimal digits with an iterative double-dabble FSM, and drives a 4-digit multiplexed common-anode 7-segment display.
- The display refreshes automatically whenever the ALU result changes.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays enabled (1 kHz per digit at 100 MHz). Legal range ≥ 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- result  input  8  signed ALU result, two's complement, range -128..127, may change any cycle
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low, always 1 (off)
- an  output  4  digit enables, active-low; an[0] = rightmost (ones) digit
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - Internals: FSM→IDLE, scan counter=0, digit index=0, displayed digits cleared to 0, sign cleared, `valid` flag cleared.
- Reset mid-conversion aborts the conversion. Display regs are cleared, not partially updated.

FSM states:
- IDLE
  - Each cycle, compare `result` against held copy `cur`.
  - If they differ, or `valid`=0, then at edge E0:
    - cur←result
    - neg←result[7]
    - mag←|result| as 8-bit unsigned (-128→128)
    - BCD shift reg←0, iteration count←0
    - go CONVERT
- CONVERT (8 cycles, edges E1..E8)
  - Per cycle: add 3 to each BCD nibble ≥5, then shift {bcd,mag} left 1.
  - Leave after the 8th shift.
- DONE (edge E9)
  - Latch hundreds/tens/ones nibbles and neg into display regs; valid←1; go IDLE.

Timing and conflict rules:
- busy=1 exactly while the state is CONVERT or DONE (9 cycles). busy=0 in IDLE.
- Latency: result sampled at E0 appears on the display regs after E9.
- Changes on `result` while busy are ignored. The IDLE compare picks up the latest value on return, so intermediate values may be skipped.
- Display regs only change at DONE, so the display never shows a partial conversion.

Scan logic (independent of FSM, runs from reset):
- Counter counts 0..SCAN_DIV-1. On wrap, digit index increments 0→1→2→3→0.
- an = ~(4'b0001 << index), registered.
- seg registered from the same index:
  - idx0 = ones
  - idx1 = tens
  - idx2 = hundreds
  - idx3 = sign: '-' (7'b0111111) if neg, else blank (7'b1111111)
- an and seg change on the same edge. Both are driven blank (all 1) only during reset.

Decoder (active-low, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Nibbles above 9 cannot occur and decode to blank.

Optional Feature:
- Macro: DISPLAY_BLANK_LEADING_ZERO_EN
- When defined:
  - Hundreds digit is blank if 0.
  - Tens digit is blank if hundreds and tens are both 0.
  - Ones is always shown.
  - The '-' stays on digit 3 (e.g. -5 shows "-  5").
- When undefined: all three numeric digits are always shown (e.g. 5 shows " 005", -5 shows "-005").
- Conversion timing and busy are identical in both builds.

Test Plan:
- Reset with result=8'sd0, SCAN_DIV=4 → busy rises the cycle after reset release for 9 cycles. Display regs then hold " 000" (undefined) or "   0" (macro defined). an cycles 1110,1101,1011,0111, each held 4 cycles.
- result=-128 (8'h80) → after E9 the digits read sign '-', 1, 2, 8. Expect seg 0111111 on an=0111 and 0000000 (8) on an=1110.
- result=127 → "_127". Then result=-1 → "-001" (undefined) or "-  1" (macro defined). Each update is preceded by exactly 9 busy cycles.
- result 5→9→12 toggled while busy → the 9 is never latched, and the final display is 12 via a second conversion started the cycle after busy falls.
- Assert rst on the 4th CONVERT cycle of result=99 → next cycle busy=0, an=1111, seg=1111111. After release a fresh conversion shows 099 (or " 99" with the macro).
- result held constant for 1000 cycles after a conversion → busy stays 0 and the display regs are unchanged.

Source files
------------

// File: rtl/alu_result_display.sv
`default_nettype none
// ---- alu_result_display: signed 8-bit result -> sign + 3 BCD digits, 4-digit muxed 7-seg (active-low)
// ---- Option: DISPLAY_BLANK_LEADING_ZERO_EN blanks leading zeros.  Rev 1.0
module alu_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int          CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_MINUS = 7'b0111111;

  logic [1:0]  state, state_nxt;
  logic [7:0]  cur;
  logic        neg;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  iter;
  logic        valid;
  logic [3:0]  disp_h, disp_t, disp_o;
  logic        disp_neg;
  logic        start;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [6:0]    seg_h, seg_t, seg_o, seg_s, seg_sel;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] adj3(input logic [3:0] n);
    adj3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign start = (result != cur) || !valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CONV;
      S_CONV:  if (iter == 3'd7) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CONV) || (state == S_DONE);
  end

  assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

  // Double-dabble datapath; display regs move only at DONE so no partial value is ever shown
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= 8'd0;
      neg      <= 1'b0;
      mag      <= 8'd0;
      bcd      <= 12'd0;
      iter     <= 3'd0;
      valid    <= 1'b0;
      disp_h   <= 4'd0;
      disp_t   <= 4'd0;
      disp_o   <= 4'd0;
      disp_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur  <= result;
            neg  <= result[7];
            mag  <= result[7] ? (~result + 8'd1) : result;
            bcd  <= 12'd0;
            iter <= 3'd0;
          end
        end
        S_CONV: begin
          bcd  <= {bcd_adj[10:0], mag[7]};
          mag  <= {mag[6:0], 1'b0};
          iter <= iter + 3'd1;
        end
        S_DONE: begin
          disp_h   <= bcd[11:8];
          disp_t   <= bcd[7:4];
          disp_o   <= bcd[3:0];
          disp_neg <= neg;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
  assign seg_h = (disp_h == 4'd0) ? SEG_BLANK : dec7(disp_h);
  assign seg_t = ((disp_h == 4'd0) && (disp_t == 4'd0)) ? SEG_BLANK : dec7(disp_t);
`else
  assign seg_h = dec7(disp_h);
  assign seg_t = dec7(disp_t);
`endif
  assign seg_o = dec7(disp_o);
  assign seg_s = disp_neg ? SEG_MINUS : SEG_BLANK;

  always_comb begin
    case (idx)
      2'd0:    seg_sel = seg_o;
      2'd1:    seg_sel = seg_t;
      2'd2:    seg_sel = seg_h;
      default: seg_sel = seg_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_sel;
    end
  end

  assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ---- tb_alu_result_display: directed + random checks of alu_result_display against a decimal model. Rev 1.0
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] result;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int last_v = 0;

  alu_result_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .result(result),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_seg(input int v, input int d);
    int m, h, t, o;
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    if (d == 3) return (v < 0) ? 7'b0111111 : 7'b1111111;
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
    if (d == 2 && h == 0) return 7'b1111111;
    if (d == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
    if (d == 2) return dec_tab[h];
    if (d == 1) return dec_tab[t];
    return dec_tab[o];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Counts consecutive busy cycles starting at a negedge where busy is already high
  task automatic count_busy(output int n);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
  endtask

  task automatic check_display(input int v, input string tag);
    logic [3:0] pat;
    bit found;
    for (int d = 0; d < 4; d++) begin
      pat = ~(4'b0001 << d);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (an === pat) found = 1;
      end
      chk($sformatf("%s_an%0d_found", tag, d), 32'(found), 32'd1);
      chk($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(exp_seg(v, d)));
    end
    chk({tag, "_dp"}, 32'(dp), 32'd1);
  endtask

  task automatic run_conv(input int v, input string tag);
    int n;
    @(negedge clk);
    result = 8'(v);
    @(negedge clk);
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    count_busy(n);
    chk({tag, "_busy_len"}, 32'(n), 32'd9);
    check_display(v, tag);
    last_v = v;
  endtask

  initial begin
    int n;
    int v;
    bit ok;
    bit found;
    logic [3:0] prev_an;

    rst = 1'b1;
    result = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("init_busy_rise", 32'(busy), 32'd1);
    count_busy(n);
    chk("init_busy_len", 32'(n), 32'd9);

    // Scan cadence: each digit enable held SCAN_DIV cycles in order 0..3
    found = 0;
    prev_an = an;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (an === 4'b1110 && prev_an !== 4'b1110) found = 1;
      prev_an = an;
    end
    chk("scan_align", 32'(found), 32'd1);
    ok = 1;
    for (int k = 0; k < 16; k++) begin
      if (an !== ~(4'b0001 << (k / 4))) ok = 0;
      @(negedge clk);
    end
    chk("scan_cadence", 32'(ok), 32'd1);
    check_display(0, "zero");

    run_conv(-128, "m128");
    run_conv(127, "p127");
    run_conv(-1, "m1");

    // Changes while busy are ignored; latest value picked up right after busy falls
    @(negedge clk);
    result = 8'd5;
    @(negedge clk);
    chk("tog_busy_rise", 32'(busy), 32'd1);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (n == 3) result = 8'd9;
      if (n == 6) result = 8'd12;
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("tog_busy_len", 32'(n), 32'd9);
    @(negedge clk);
    chk("tog_second_rise", 32'(busy), 32'd1);
    count_busy(n);
    chk("tog_second_len", 32'(n), 32'd9);
    check_display(12, "tog12");
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 0;
    end
    chk("tog_no_third", 32'(ok), 32'd1);
    last_v = 12;

    for (int r = 0; r < 8; r++) begin
      v = int'($signed(8'($urandom)));
      if (v == last_v) v = (v == 127) ? -128 : v + 1;
      run_conv(v, $sformatf("rnd%0d", r));
    end

    // Reset during the 4th CONVERT cycle
    @(negedge clk);
    result = 8'd99;
    @(negedge clk);
    chk("abort_busy_rise", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_an", 32'(an), 32'hF);
    chk("abort_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_reconv_rise", 32'(busy), 32'd1);
    count_busy(n);
    chk("abort_reconv_len", 32'(n), 32'd9);
    check_display(99, "d99");

    // Constant input: no new conversions, display steady
    ok = 1;
    found = 1;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 0;
      for (int d = 0; d < 4; d++)
        if (an === ~(4'b0001 << d) && seg !== exp_seg(99, d)) found = 0;
    end
    chk("hold_busy_low", 32'(ok), 32'd1);
    chk("hold_display", 32'(found), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
